// File: rtl/shift_add_multiplier_pkg.sv
// shift_add_multiplier_pkg: state encoding and counter sizing shared by the multiplier files
package shift_add_multiplier_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/shift_add_multiplier_mul_step.sv
// shift_add_multiplier_mul_step: one conditional add of mcand into acc, then right shift of {acc,mplr}
module shift_add_multiplier_mul_step #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] mplr,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] mplr_next
);
  logic [WIDTH:0] sum;
  always_comb begin
    sum = acc + (mplr[0] ? {1'b0, mcand} : '0);
    acc_next = sum[WIDTH:1];
    mplr_next = {sum[0], mplr[WIDTH-1:1]};
  end
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential signed/unsigned shift-and-add multiplier with start/busy/done handshake
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);
  localparam int CW = cnt_w(WIDTH);
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic sign;
  logic [WIDTH-1:0] mcand, mplr, a_mag, b_mag, acc_n, mplr_n;
  logic [WIDTH:0] acc;
  logic [2*WIDTH-1:0] mag;
  shift_add_multiplier_mul_step #(.WIDTH(WIDTH)) u_step (
    .acc(acc),
    .mplr(mplr),
    .mcand(mcand),
    .acc_next(acc_n),
    .mplr_next(mplr_n)
  );
  always_comb begin
    a_mag = (signed_mode & a[WIDTH-1]) ? -a : a;
    b_mag = (signed_mode & b[WIDTH-1]) ? -b : b;
    mag = {acc_n, mplr_n};
    busy = state != ST_IDLE;
    done = state == ST_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      sign <= 1'b0;
      mcand <= '0;
      mplr <= '0;
      acc <= '0;
      p <= '0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        state <= ST_RUN;
        sign <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        mcand <= a_mag;
        mplr <= b_mag;
        acc <= '0;
        cnt <= '0;
      end
    end else if (state == ST_RUN) begin
      acc <= {1'b0, acc_n};
      mplr <= mplr_n;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(WIDTH - 1)) begin
        state <= ST_DONE;
        p <= sign ? -mag : mag;
      end
    end else begin
      state <= ST_IDLE;
    end
  end
endmodule
